load_store_unit: RTL

//  Request/response front end for the 4 KiB word-wide `memory` array. Accepts RV32 loads/stores
//  (LB/LH/LW/LBU/LHU/SB/SH/SW), drives the array's word port, sign/zero-extends load data and

---
 rtl/load_store_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Request/response front end for a word-wide memory array. Handles RV32
//   loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW). It drives the array's word
//   port and sign/zero-extends the load data. The array can only write whole
//   words, so SB and SH are done as read-modify-write. A misaligned,
//   out-of-range or illegal-funct3 request gets an error response and causes
//   no write. Only one request is in flight at a time.
//
// Ports
//   clock, reset            single clock; synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_store               1 = store, 0 = load
//   req_funct3              RV32 load/store funct3
//   req_addr                byte address
//   req_wdata               store data (low byte/half used for SB/SH)
//   rsp_valid/rsp_ready     response handshake; response held until taken
//   rsp_data                extended load result; 0 for stores and errors
//   rsp_error               misaligned / out of range / illegal funct3
//   mem_non_load            array word write enable
//   mem_funct3              funct3 of the access in flight
//   mem_addr                word index {2'b0, byte_addr[31:2]}
//   mem_wdata               word to write
//   mem_rdata               array read data, one cycle after mem_addr
//
// state        | meaning
// -------------+--------------------------------------------------------
// S_IDLE       | ready; mem port follows req_* so the array read starts
// S_LOAD_DATA  | mem_rdata holds the addressed word; extract and register
// S_RMW_MERGE  | mem_rdata holds the old word; merge lane(s) and write back
// S_RESP       | response presented until rsp_ready
module load_store_unit #(
    parameter int WORDS_LOG2 = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        mem_non_load,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD_DATA = 2'd1,
        S_RMW_MERGE = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic        store_q;
    logic [31:0] rsp_data_q;
    logic        rsp_error_q;

    logic        accept;
    logic        funct3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        req_is_sw;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request decode; only meaningful in S_IDLE, where it is used.
    always_comb begin
        accept = req_valid & req_ready;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = ~req_store;
            default:                funct3_ok = 1'b0;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                     | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
        out_of_range = (req_addr >> (WORDS_LOG2 + 2)) != 32'd0;
        req_err      = ~funct3_ok | misaligned | out_of_range;
        req_is_sw    = req_store & (req_funct3 == 3'b010);
    end

    // Lane extraction for loads and lane merge for SB/SH.
    always_comb begin
        byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_ext = mem_rdata;
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = 32'd0;
        endcase

        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (funct3_q[1:0] == 2'b01) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged = wdata_q;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)        state_nxt = S_RESP;
                    else if (req_is_sw) state_nxt = S_RESP;
                    else if (req_store) state_nxt = S_RMW_MERGE;
                    else                state_nxt = S_LOAD_DATA;
                end
            end
            S_LOAD_DATA: state_nxt = S_RESP;
            S_RMW_MERGE: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs. The write enable is gated by reset so that an abort in
    // S_RMW_MERGE never reaches the array.
    always_comb begin
        req_ready    = (state == S_IDLE) & ~reset;
        rsp_valid    = (state == S_RESP);
        rsp_data     = rsp_data_q;
        rsp_error    = rsp_error_q;
        mem_addr     = {2'b00, addr_q[31:2]};
        mem_funct3   = funct3_q;
        mem_wdata    = wdata_q;
        mem_non_load = 1'b0;
        case (state)
            S_IDLE: begin
                mem_addr     = {2'b00, req_addr[31:2]};
                mem_funct3   = req_funct3;
                mem_wdata    = req_wdata;
                mem_non_load = accept & req_is_sw & ~req_err & ~reset;
            end
            S_RMW_MERGE: begin
                mem_wdata    = merged;
                mem_non_load = store_q & ~reset;
            end
            default: ;
        endcase
    end

    // Request latch and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q      <= 32'd0;
            funct3_q    <= 3'd0;
            wdata_q     <= 32'd0;
            store_q     <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr;
                        funct3_q    <= req_funct3;
                        wdata_q     <= req_wdata;
                        store_q     <= req_store;
                        rsp_data_q  <= 32'd0;
                        rsp_error_q <= req_err;
                    end
                end
                S_LOAD_DATA: begin
                    rsp_data_q <= load_ext;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_data_q  <= 32'd0;
                        rsp_error_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
